// File: rtl/osc_meas_pkg.sv
// Shared constants and FSM encoding for the oscillator edge counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package osc_meas_pkg;

    // Default gate window length in clk cycles.
    localparam int OSC_GATE_CYCLES_DEF = 1000;

    // Default width of the measurement result.
    localparam int OSC_OUT_W = 8;

    // Width of the gate down-counter; covers the full legal window range.
    localparam int OSC_GATE_W = 16;

    // FSM encoding, kept as plain constants for older tools.
    typedef logic [1:0] osc_state_t;
    localparam osc_state_t ST_IDLE = 2'd0;
    localparam osc_state_t ST_GATE = 2'd1;
    localparam osc_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/osc_sync_edge.sv
// Synchronises the raw oscillator and emits a one-cycle pulse per rising edge.
// Latency: 3 cycles pin-to-count, 5 with OSC_FILTER_EN (3-sample majority filter).
// Backpressure: none; at most one edge per clk cycle, faster inputs alias.
module osc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic rise
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;

`ifdef OSC_FILTER_EN
    logic hist_q1;
    logic hist_q2;
    logic filt_q;

    // Two-flop synchroniser, two history taps, registered majority vote and edge reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            hist_q1 <= 1'b0;
            hist_q2 <= 1'b0;
            filt_q  <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= osc_in;
            sync_q2 <= sync_q1;
            hist_q1 <= sync_q2;
            hist_q2 <= hist_q1;
            filt_q  <= (sync_q2 & hist_q1) | (sync_q2 & hist_q2) | (hist_q1 & hist_q2);
            prev_q  <= filt_q;
        end
    end

    assign rise = filt_q & ~prev_q;
`else
    // Two-flop synchroniser followed by the edge-detect reference flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= osc_in;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~prev_q;
`endif

endmodule

// File: rtl/osc_edge_counter.sv
// Gated frequency counter: counts oscillator rising edges over GATE_CYCLES clk cycles, saturating result.
// Latency: result strobes GATE_CYCLES+1 cycles after start; edges seen 3 cycles late (5 with OSC_FILTER_EN).
// Backpressure: none; start ignored unless idle, meas held until next result.
module osc_edge_counter
    import osc_meas_pkg::*;
#(
    parameter int GATE_CYCLES = OSC_GATE_CYCLES_DEF,
    parameter int OUT_W       = OSC_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [OUT_W-1:0] meas,
    output logic             meas_valid,
    output logic             overflow
);

    localparam logic [OSC_GATE_W-1:0] GATE_LOAD = OSC_GATE_W'(GATE_CYCLES - 1);
    localparam logic [OUT_W-1:0]      EDGE_MAX  = '1;

    osc_state_t            state;
    logic [OSC_GATE_W-1:0] gate_cnt;
    logic [OUT_W-1:0]      edge_cnt;
    logic                  sat;
    logic [OUT_W-1:0]      edge_nxt;
    logic                  sat_nxt;
    logic                  rise;
    logic                  gate_open;
    logic                  gate_last;

    osc_sync_edge u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .rise   (rise)
    );

    // A new window opens from IDLE on start, or straight out of DONE in continuous mode.
    assign gate_open = ((state == ST_IDLE) && start) || ((state == ST_DONE) && continuous);
    assign gate_last = (state == ST_GATE) && (gate_cnt == '0);

    // Saturating next count; the sticky flag records edges lost at the ceiling.
    always_comb begin
        edge_nxt = edge_cnt;
        sat_nxt  = sat;
        if (rise) begin
            if (edge_cnt == EDGE_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + OUT_W'(1);
            end
        end
    end

    // Window sequencing: IDLE -> GATE for exactly GATE_CYCLES cycles -> one DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            gate_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gate_open) begin
                        state    <= ST_GATE;
                        gate_cnt <= GATE_LOAD;
                    end
                end
                ST_GATE: begin
                    if (gate_last) begin
                        state <= ST_DONE;
                    end else begin
                        gate_cnt <= gate_cnt - OSC_GATE_W'(1);
                    end
                end
                ST_DONE: begin
                    if (gate_open) begin
                        state    <= ST_GATE;
                        gate_cnt <= GATE_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Edge counter runs only inside the window and is cleared whenever a window opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (gate_open) begin
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (state == ST_GATE) begin
            edge_cnt <= edge_nxt;
            sat      <= sat_nxt;
        end
    end

    // Result captured on the last gate cycle (including its edge) so it is visible throughout DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas     <= '0;
            overflow <= 1'b0;
        end else if (gate_last) begin
            meas     <= edge_nxt;
            overflow <= sat_nxt;
        end
    end

    assign busy       = (state == ST_GATE);
    assign meas_valid = (state == ST_DONE);

endmodule

// File: tb/tb_osc_edge_counter.sv
// Self-checking bench for osc_edge_counter: scoreboard of expected results per measurement.
// Latency: n/a.
// Backpressure: n/a.
module tb_osc_edge_counter;

    typedef struct packed {
        logic [7:0] m;
        logic       o;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       osc;
    logic       start;
    logic       cont;
    logic       busy;
    logic [7:0] meas;
    logic       meas_valid;
    logic       overflow;

    logic       start_sat;
    logic       busy_sat;
    logic [7:0] meas_sat;
    logic       meas_valid_sat;
    logic       overflow_sat;

    int   osc_half;
    int   total;
    int   bad;
    exp_t exp_q[$];

    osc_edge_counter #(.GATE_CYCLES(100), .OUT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .osc_in     (osc),
        .start      (start),
        .continuous (cont),
        .busy       (busy),
        .meas       (meas),
        .meas_valid (meas_valid),
        .overflow   (overflow)
    );

    osc_edge_counter #(.GATE_CYCLES(1000), .OUT_W(8)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .osc_in     (osc),
        .start      (start_sat),
        .continuous (1'b0),
        .busy       (busy_sat),
        .meas       (meas_sat),
        .meas_valid (meas_valid_sat),
        .overflow   (overflow_sat)
    );

    // 10-unit clock; rising edges on odd multiples of 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oscillator offset by 2 so its edges never coincide with clk edges.
    initial begin
        osc = 1'b0;
        #2;
        forever begin
            #(osc_half) osc = ~osc;
        end
    end

    // Starts a gate on dut and watches it; optional second start pulse at restart_at.
    task automatic run_gate(input int cycles, input int restart_at,
                            output int nb, output int ns, output int first_at,
                            output logic [7:0] m_first, output logic o_first, output logic busy_at);
        nb = 0; ns = 0; first_at = -1; m_first = '0; o_first = 1'b0; busy_at = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= cycles; i++) begin
            @(negedge clk);
            start = (i == restart_at);
            if (busy) nb++;
            if (meas_valid) begin
                ns++;
                if (ns == 1) begin
                    first_at = i; m_first = meas; o_first = overflow; busy_at = busy;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (meas !== 8'd0) begin bad++; $display("FAIL reset_meas got=%0d exp=0", meas); end
        total++; if (meas_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", meas_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_shot();
        int nb, ns, fa;
        logic [7:0] m;
        logic o, b;
        exp_t e;
        exp_q.delete();
        osc_half = 50;
        repeat (10) @(negedge clk);
        e.m = 8'd10; e.o = 1'b0; exp_q.push_back(e);
        run_gate(250, -1, nb, ns, fa, m, o, b);
        total++; if (nb != 100) begin bad++; $display("FAIL single_busy_cycles got=%0d exp=100", nb); end
        total++; if (ns != 1) begin bad++; $display("FAIL single_strobes got=%0d exp=1", ns); end
        total++; if (fa != 101) begin bad++; $display("FAIL single_done_cycle got=%0d exp=101", fa); end
        total++; if (b !== 1'b0) begin bad++; $display("FAIL single_busy_in_done got=%b exp=0", b); end
        if (ns > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++; if (m !== e.m) begin bad++; $display("FAIL single_meas got=%0d exp=%0d", m, e.m); end
            total++; if (o !== e.o) begin bad++; $display("FAIL single_ovf got=%b exp=%b", o, e.o); end
        end
        total++; if (meas !== 8'd10) begin bad++; $display("FAIL single_meas_held got=%0d exp=10", meas); end
    endtask

    task automatic test_saturation();
        int got;
        exp_t e;
        exp_q.delete();
        for (int run = 0; run < 2; run++) begin
            osc_half = (run == 0) ? 15 : 50;
            repeat (20) @(negedge clk);
            e.m = (run == 0) ? 8'd255 : 8'd100;
            e.o = (run == 0);
            exp_q.push_back(e);
            start_sat = 1'b1;
            got = 0;
            for (int i = 1; i <= 1200 && got == 0; i++) begin
                @(negedge clk);
                start_sat = 1'b0;
                if (meas_valid_sat) begin
                    got = 1;
                    e = exp_q.pop_front();
                    total++; if (i != 1001) begin bad++; $display("FAIL sat_done_cycle run=%0d got=%0d exp=1001", run, i); end
                    total++; if (meas_sat !== e.m) begin bad++; $display("FAIL sat_meas run=%0d got=%0d exp=%0d", run, meas_sat, e.m); end
                    total++; if (overflow_sat !== e.o) begin bad++; $display("FAIL sat_ovf run=%0d got=%b exp=%b", run, overflow_sat, e.o); end
                end
            end
            if (got == 0) begin
                total++; bad++;
                $display("FAIL sat_timeout run=%0d got=no_strobe exp=strobe", run);
            end
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_continuous();
        int st[$];
        logic [7:0] mv[$];
        logic ov[$];
        exp_t e;
        int lo, hi;
        exp_q.delete();
        osc_half = 25;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            e.m = 8'd20; e.o = 1'b0; exp_q.push_back(e);
        end
        cont = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 700; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (st.size() == 3 && i == st[2] + 50) cont = 1'b0;
            if (meas_valid) begin
                st.push_back(i); mv.push_back(meas); ov.push_back(overflow);
            end
        end
        cont = 1'b0;
        total++; if (st.size() != 4) begin bad++; $display("FAIL cont_strobes got=%0d exp=4", st.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle_busy got=%b exp=0", busy); end
        if (st.size() >= 1) begin
            total++; if (st[0] != 101) begin bad++; $display("FAIL cont_first_cycle got=%0d exp=101", st[0]); end
        end
        for (int k = 1; k < st.size(); k++) begin
            total++; if (st[k] - st[k-1] != 101) begin bad++; $display("FAIL cont_interval k=%0d got=%0d exp=101", k, st[k] - st[k-1]); end
        end
        for (int k = 0; k < mv.size() && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            lo = int'(e.m) - 1; hi = int'(e.m) + 1;
            total++; if (int'(mv[k]) < lo || int'(mv[k]) > hi) begin bad++; $display("FAIL cont_meas k=%0d got=%0d exp=%0d+-1", k, mv[k], e.m); end
            total++; if (ov[k] !== e.o) begin bad++; $display("FAIL cont_ovf k=%0d got=%b exp=%b", k, ov[k], e.o); end
        end
    endtask

    task automatic test_start_busy();
        int nb, ns, fa;
        logic [7:0] m;
        logic o, b;
        exp_t e;
        exp_q.delete();
        osc_half = 50;
        repeat (10) @(negedge clk);
        e.m = 8'd10; e.o = 1'b0; exp_q.push_back(e);
        run_gate(250, 40, nb, ns, fa, m, o, b);
        total++; if (nb != 100) begin bad++; $display("FAIL busy_restart_cycles got=%0d exp=100", nb); end
        total++; if (ns != 1) begin bad++; $display("FAIL busy_restart_strobes got=%0d exp=1", ns); end
        total++; if (fa != 101) begin bad++; $display("FAIL busy_restart_done got=%0d exp=101", fa); end
        if (ns > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++; if (m !== e.m) begin bad++; $display("FAIL busy_restart_meas got=%0d exp=%0d", m, e.m); end
        end
    endtask

    task automatic test_reset_mid();
        int ns, nb, fa;
        logic [7:0] m;
        logic o, b;
        exp_t e;
        exp_q.delete();
        osc_half = 50;
        repeat (10) @(negedge clk);
        ns = 0;
        start = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 51) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
                total++; if (meas !== 8'd0) begin bad++; $display("FAIL rstmid_meas got=%0d exp=0", meas); end
                total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_ovf got=%b exp=0", overflow); end
            end
            rst = (i == 50);
            if (meas_valid) ns++;
        end
        rst = 1'b0;
        total++; if (ns != 0) begin bad++; $display("FAIL rstmid_strobes got=%0d exp=0", ns); end
        e.m = 8'd10; e.o = 1'b0; exp_q.push_back(e);
        run_gate(200, -1, nb, ns, fa, m, o, b);
        total++; if (ns != 1) begin bad++; $display("FAIL rstmid_fresh_strobes got=%0d exp=1", ns); end
        if (ns > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++; if (m !== e.m) begin bad++; $display("FAIL rstmid_fresh_meas got=%0d exp=%0d", m, e.m); end
            total++; if (o !== e.o) begin bad++; $display("FAIL rstmid_fresh_ovf got=%b exp=%b", o, e.o); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        osc_half = 30;
        rst = 1'b1; start = 1'b0; cont = 1'b0; start_sat = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_shot();
        test_saturation();
        test_continuous();
        test_start_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
